// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer.
// Note divider table, FSM states and command field offsets.
package tone_seq_pkg;

  localparam int NOTE_REST_MIN = 12;

  // Offsets above the duration field inside cmd_data.
  localparam int NOTE_OFS = 0;
  localparam int OCT_OFS  = 4;
  localparam int REST_OFS = 8;
  localparam int HDR_W    = 9;

  localparam logic [9:0] BASE_DIV [0:11] = '{
    10'd512, 10'd483, 10'd456, 10'd431,
    10'd406, 10'd384, 10'd362, 10'd342,
    10'd323, 10'd304, 10'd287, 10'd271
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  function automatic logic [9:0] base_div(
    input logic [3:0] n
  );
    logic [3:0] i;
    i = (n < 4'(NOTE_REST_MIN)) ? n : 4'd0;
    return BASE_DIV[i];
  endfunction

endpackage

// File: rtl/tone_seq_tone.sv
// Square-wave pitch generator: note divider chained with
// an octave divider; toggles when both wrap together.
module tone_gen
  import tone_seq_pkg::*;
#(
  parameter int MAX_SHIFT = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic [3:0] note,
  input  logic [3:0] octave,
  input  logic       rest,
  output logic       square
);

  localparam int OW  = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam int OW1 = OW + 1;
  localparam logic [3:0] MS = 4'(MAX_SHIFT);

  logic [9:0]    note_cnt;
  logic [9:0]    note_load;
  logic [OW-1:0] oct_cnt;
  logic [OW-1:0] oct_load;
  logic [OW:0]   span;
  logic [3:0]    oct_eff;
  logic [3:0]    shift;
  logic          silent;

  // Reload values: clamped octave sets the octave divide ratio.
  always_comb begin
    oct_eff   = (octave > MS) ? MS : octave;
    shift     = MS - oct_eff;
    span      = OW1'(1) << shift;
    oct_load  = OW'(span - 1'b1);
    note_load = base_div(note) - 10'd1;
    silent    = rest || (note >= 4'(NOTE_REST_MIN));
  end

  // Divider chain; rests and invalid notes keep the output low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      note_cnt <= '0;
      oct_cnt  <= '0;
      square   <= 1'b0;
    end else if (clear) begin
      note_cnt <= note_load;
      oct_cnt  <= oct_load;
      square   <= 1'b0;
    end else if (!silent) begin
      if (note_cnt == '0) begin
        note_cnt <= note_load;
        if (oct_cnt == '0) begin
          oct_cnt <= oct_load;
          square  <= ~square;
        end else begin
          oct_cnt <= oct_cnt - 1'b1;
        end
      end else begin
        note_cnt <= note_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Queued note player: command FIFO, tick prescaler and FSM.
// Optional volume gating with TONE_SEQ_VOLUME_EN.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int CLK_HZ     = 16000000,
  parameter int TICK_HZ    = 100,
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_W      = 8,
  parameter int MAX_SHIFT  = 8,
  parameter int GAP_TICKS  = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [HDR_W+DUR_W-1:0]      cmd_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        stop,
`ifdef TONE_SEQ_VOLUME_EN
  input  logic [1:0]                  vol,
`endif
  output logic                        AUDIO,
  output logic                        busy,
  output logic                        note_done,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = HDR_W + DUR_W;
  localparam int PW = $clog2(TICK_CYC);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int TW = (DUR_W > GW) ? DUR_W : GW;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [CW-1:0] hold;
  logic [PW-1:0] pre;
  logic [TW-1:0] tcnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic pre_wrap;
  logic tick_last;
  logic tone_clr;
  logic gap_go;
  logic done;
  logic square;

  logic [DUR_W-1:0] h_dur;
  logic [3:0]       h_note;
  logic [3:0]       h_oct;
  logic             h_rest;

  assign h_dur  = hold[DUR_W-1:0];
  assign h_note = hold[DUR_W+NOTE_OFS +: 4];
  assign h_oct  = hold[DUR_W+OCT_OFS +: 4];
  assign h_rest = hold[DUR_W+REST_OFS];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

  // A stop cycle neither accepts nor pops.
  assign cmd_ready = !full && !stop;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty && !stop;

  assign pre_wrap  = (pre == PW'(TICK_CYC - 1));
  assign tick_last = pre_wrap && (tcnt == TW'(1));

  assign busy      = (state != IDLE);
  assign note_done = done;

  // Command storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= cmd_data;
    end
  end

  // FIFO pointers; stop flushes the queue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else if (stop) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Holding register for the entry being played.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold <= '0;
    end else if (pop) begin
      hold <= mem[rptr[AW-1:0]];
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    tone_clr = 1'b0;
    gap_go   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) state_nx = LOAD;
      end
      LOAD: begin
        tone_clr = 1'b1;
        state_nx = (h_dur == '0) ? IDLE : PLAY;
      end
      PLAY: begin
        if (tick_last) begin
          if (GAP_TICKS == 0) begin
            state_nx = IDLE;
            done     = 1'b1;
          end else begin
            state_nx = GAP;
            gap_go   = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick_last) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (stop) begin
      state_nx = IDLE;
      done     = 1'b0;
    end
  end

  // Tick prescaler and remaining-tick counter for PLAY/GAP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre  <= '0;
      tcnt <= '0;
    end else if (stop) begin
      pre  <= '0;
      tcnt <= '0;
    end else if (state == LOAD) begin
      pre  <= '0;
      tcnt <= TW'(h_dur);
    end else if (gap_go) begin
      pre  <= '0;
      tcnt <= TW'(GAP_TICKS);
    end else if (state == PLAY || state == GAP) begin
      if (pre_wrap) begin
        pre  <= '0;
        tcnt <= tcnt - 1'b1;
      end else begin
        pre  <= pre + 1'b1;
      end
    end
  end

  tone_gen #(
    .MAX_SHIFT (MAX_SHIFT)
  ) u_tone (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (tone_clr),
    .note   (h_note),
    .octave (h_oct),
    .rest   (h_rest),
    .square (square)
  );

`ifdef TONE_SEQ_VOLUME_EN
  logic [1:0] vol_q;
  logic [1:0] pwm_cnt;
  logic       gate;

  // Volume latched per entry; PWM phase restarts with each note.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vol_q   <= '0;
      pwm_cnt <= '0;
    end else if (state == LOAD) begin
      vol_q   <= vol;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign gate  = {1'b0, pwm_cnt} < ({1'b0, vol_q} + 3'd1);
  assign AUDIO = (state == PLAY) && square && gate;
`else
  assign AUDIO = (state == PLAY) && square;
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer.
// TICK_CYC=10, GAP_TICKS=1, 8-entry FIFO.
module tb_tone_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [16:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        stop = 1'b0;
  logic        cmd_ready;
  logic        AUDIO;
  logic        busy;
  logic        note_done;
  logic [3:0]  level;
`ifdef TONE_SEQ_VOLUME_EN
  logic [1:0]  vol = 2'd3;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nd_cnt = 0;
  int c0;
  int nd0;
  int hi;

  tone_sequencer #(
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .FIFO_DEPTH (8),
    .DUR_W      (8),
    .MAX_SHIFT  (8),
    .GAP_TICKS  (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .stop      (stop),
`ifdef TONE_SEQ_VOLUME_EN
    .vol       (vol),
`endif
    .AUDIO     (AUDIO),
    .busy      (busy),
    .note_done (note_done),
    .level     (level)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (note_done === 1'b1) nd_cnt <= nd_cnt + 1;
  end

  function automatic logic [16:0] mk(
    input logic       rest,
    input logic [3:0] oct,
    input logic [3:0] note,
    input logic [7:0] dur
  );
    return {rest, oct, note, dur};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic push(input logic [16:0] c);
    @(negedge CLK);
    cmd_data  = c;
    cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_audio", AUDIO, 0);
    check("rst_busy", busy, 0);
    check("rst_done", note_done, 0);
    check("rst_level", level, 0);
    check("rst_ready", cmd_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    // single note A, octave 8, 200 ticks
    nd0 = nd_cnt;
    push(mk(1'b0, 4'd8, 4'd0, 8'd200));
    c0 = cyc;
    check("t1_level", level, 1);
    at(c0 + 1);    check("t1_busy_load", busy, 1);
    at(c0 + 513);  check("t1_pre_tog", AUDIO, 0);
    at(c0 + 514);  check("t1_tog1", AUDIO, 1);
    at(c0 + 1025); check("t1_pre_tog2", AUDIO, 1);
    at(c0 + 1026); check("t1_tog2", AUDIO, 0);
    at(c0 + 1538); check("t1_tog3", AUDIO, 1);
    at(c0 + 2001);
    check("t1_last_play", AUDIO, 1);
    check("t1_busy_play", busy, 1);
    at(c0 + 2002); check("t1_gap_low", AUDIO, 0);
    at(c0 + 2010); check("t1_no_done", note_done, 0);
    at(c0 + 2011); check("t1_done", note_done, 1);
    at(c0 + 2012);
    check("t1_done_end", note_done, 0);
    check("t1_idle", busy, 0);
    check("t1_pulses", nd_cnt - nd0, 1);

    // octave scaling: C, octave 7 -> 862-cycle half period
    push(mk(1'b0, 4'd7, 4'd3, 8'd200));
    c0 = cyc;
    at(c0 + 863);  check("t2_pre_tog", AUDIO, 0);
    at(c0 + 864);  check("t2_tog1", AUDIO, 1);
    at(c0 + 1725); check("t2_pre_tog2", AUDIO, 1);
    at(c0 + 1726); check("t2_tog2", AUDIO, 0);
    at(c0 + 2012); check("t2_idle", busy, 0);

    // rest and invalid note
    nd0 = nd_cnt;
    push(mk(1'b1, 4'd8, 4'd0, 8'd5));
    c0 = cyc;
    push(mk(1'b0, 4'd8, 4'd13, 8'd5));
    hi = 0;
    for (int n = 1; n <= 124; n++) begin
      at(c0 + n);
      if (AUDIO !== 1'b0) hi++;
      if (n == 61 || n == 123) check("t3_done", note_done, 1);
    end
    check("t3_silent", hi, 0);
    check("t3_pulses", nd_cnt - nd0, 2);
    check("t3_idle", busy, 0);

    // zero-duration entries are skipped
    nd0 = nd_cnt;
    push(mk(1'b0, 4'd8, 4'd0, 8'd0));
    c0 = cyc;
    push(mk(1'b0, 4'd8, 4'd0, 8'd1));
    push(mk(1'b0, 4'd8, 4'd0, 8'd0));
    at(c0 + 2);  check("t4_skip_idle", busy, 0);
    at(c0 + 3);  check("t4_load", busy, 1);
    at(c0 + 23); check("t4_done", note_done, 1);
    at(c0 + 25); check("t4_load2", busy, 1);
    at(c0 + 26); check("t4_skip2", busy, 0);
    at(c0 + 30); check("t4_pulses", nd_cnt - nd0, 1);

    // fill the FIFO with cmd_valid held high
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      cmd_valid = 1'b1;
      if (k == 0)      cmd_data = mk(1'b0, 4'd8, 4'd0, 8'd10);
      else if (k == 3) cmd_data = mk(1'b0, 4'd8, 4'd11, 8'd100);
      else             cmd_data = mk(1'b0, 4'd8, 4'd0, 8'd1);
      @(posedge CLK);
      if (k == 0) begin
        #1;
        c0 = cyc;
      end
    end
    #1;
    cmd_valid = 1'b0;
    at(c0 + 8);
    check("t5_level8", level, 8);
    check("t5_full", cmd_ready, 0);
    at(c0 + 112);
    check("t5_still_full", cmd_ready, 0);
    at(c0 + 113);
    check("t5_ready", cmd_ready, 1);
    check("t5_level7", level, 7);

    // stop mid-PLAY with a same-cycle push
    at(c0 + 440);
    check("t6_level5", level, 5);
    check("t6_audio_hi", AUDIO, 1);
    stop      = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = mk(1'b0, 4'd8, 4'd0, 8'd1);
    #1;
    check("t6_ready_low", cmd_ready, 0);
    @(posedge CLK);
    #1;
    check("t6_level0", level, 0);
    check("t6_audio0", AUDIO, 0);
    check("t6_busy0", busy, 0);
    check("t6_no_done", note_done, 0);
    stop      = 1'b0;
    cmd_valid = 1'b0;
    at(c0 + 443);
    check("t6_dropped", level, 0);
    check("t6_stay_idle", busy, 0);

    // asynchronous reset mid-GAP
    push(mk(1'b0, 4'd8, 4'd11, 8'd1));
    c0 = cyc;
    push(mk(1'b0, 4'd8, 4'd11, 8'd1));
    at(c0 + 15);
    check("t7_busy_gap", busy, 1);
    check("t7_level1", level, 1);
    #1;
    RST = 1'b1;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_audio", AUDIO, 0);
    check("t7_rst_done", note_done, 0);
    check("t7_rst_level", level, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("t7_post_busy", busy, 0);
    check("t7_post_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
